fsk_symbol_sequencer: RTL and testbench
=======================================

// Module: fsk_symbol_sequencer
// PURPOSE
// - Upstream feeder of the FSK NCO: takes bytes over a valid/ready handshake, serialises them LSB first
//   and drives the NCO phase-increment input with the mark word (bit 1) or the space word (bit 0).
// - Each symbol lasts a run-time number of clken-qualified cycles. Idle line sits on mark.
// PARAMETERS
// - APR    32  phase-increment width; equals the NCO accumulator width
// - SPS_W  16  width of the samples-per-symbol port
// PORTS
// - clk        in   1      single clock; all flops rise on posedge clk
// - reset      in   1      asynchronous, active-high reset
// - clken      in   1      clock enable shared with the NCO; all state advances only when clken=1
// - sps        in   SPS_W  clken cycles per symbol; sampled at byte acceptance; 0 is treated as 1
// - mark_inc   in   APR    phase increment for bit 1 / idle
// - space_inc  in   APR    phase increment for bit 0
// - in_data    in   8      byte to transmit
// - in_valid   in   1      in_data is valid
// - in_ready   out  1      sequencer can accept a byte this cycle (combinational)
// - phi_inc_o  out  APR    to NCO phi_inc_i; registered
// - sym_strobe out  1      1-cycle pulse on the edge where a new symbol begins; registered
// - busy       out  1      a byte is being transmitted; registered
// BEHAVIOUR
// - Reset values: phi_inc_o=0, sym_strobe=0, busy=0; state=IDLE, cnt=0, idx=0, shreg=0.
// - While reset is high, in_ready=0.
// - Transfer happens on a rising edge with in_valid & in_ready & clken. Neither side may drop valid/data
//   while waiting. Without clken no transfer occurs, even with in_ready=1.
// - in_ready = (state==IDLE) | (state==SHIFT & idx==NSYM-1 & cnt==sps_q-1).
//   This allows back-to-back bytes with no idle symbol between them.
// - States:
//   - IDLE: on each clken edge, phi_inc_o <= mark_inc.
//     On transfer: shreg <= frame(in_data), sps_q <= max(sps,1), cnt <= 0, idx <= 0,
//     phi_inc_o <= inc(symbol 0), sym_strobe <= 1, busy <= 1, go to SHIFT.
//   - SHIFT: on each clken edge, cnt++.
//     - At cnt==sps_q-1 and idx<NSYM-1: cnt <= 0, idx++, phi_inc_o <= inc(next symbol),
//       sym_strobe <= 1.
//     - At cnt==sps_q-1 and idx==NSYM-1: if a transfer occurs this edge, reload exactly as in IDLE and
//       stay in SHIFT. Otherwise go to IDLE, busy <= 0, phi_inc_o <= mark_inc.
// - inc(b) = b ? mark_inc : space_inc. mark_inc and space_inc are sampled at every symbol start.
//   In IDLE they are sampled every clken cycle.
// - Latency: phi_inc_o shows symbol 0 on the transfer edge itself. Symbol k occupies clken cycles
//   [k*sps_q, (k+1)*sps_q).
// - Counters: cnt is SPS_W bits and never wraps past sps_q-1. idx is 4 bits. NSYM is 8 or 10
//   (see CONFIGURATION).
// - sym_strobe falls back to 0 on the next clk edge regardless of clken.
// - A reset asserted mid-byte aborts the byte: all outputs take reset values asynchronously and the
//   byte is lost. After reset release, the first clken edge in IDLE loads mark_inc.
// CONFIGURATION
// - Macro FSK_SEQ_FRAMING_EN.
// - Defined: frame = start bit 0, in_data[0..7] LSB first, stop bit 1; NSYM=10.
// - Undefined: frame = in_data[0..7] LSB first with no start/stop; NSYM=8.
// - All other behaviour is identical in both builds.
// TESTING
// - Reset: reset=1 mid-byte -> phi_inc_o=0, busy=0, in_ready=0.
//   Release with clken=1 and mark_inc=32'h0400_0000 -> phi_inc_o=32'h0400_0000 after 1 clk.
// - Single byte: sps=4, clken=1, mark=32'h0400_0000, space=32'h0200_0000, in_data=8'hA5, no framing
//   -> phi_inc_o pattern M,S,M,S,S,M,S,M, each held 4 clk.
//   -> 8 sym_strobe pulses; busy high 32 clk; then idle at mark.
// - Framing (FSK_SEQ_FRAMING_EN): in_data=8'h00, sps=2 -> S for 18 clk, then M for 2 clk, then idle M.
//   -> busy high 20 clk.
// - Back-to-back: in_valid held with 8'hFF then 8'h00, sps=3
//   -> in_ready pulses only on the last cycle of symbol 7.
//   -> the second byte's first symbol starts on the very next clk; no idle gap; busy never drops.
// - clken gating: sps=2, clken toggling 1,0,1,0 -> each symbol spans 4 clk.
//   -> no transfer on a clken=0 cycle even with in_valid=in_ready=1.
// - sps=0 corner: sps=0, in_data=8'h01 -> each symbol lasts 1 clken cycle; behaves identically to sps=1.

Source files
------------

// File: rtl/fsk_symbol_sequencer.sv
// FSK symbol sequencer: serialises bytes LSB first into NCO mark/space phase increments.
// Define FSK_SEQ_FRAMING_EN to wrap each byte with a start bit (0) and stop bit (1).
module fsk_symbol_sequencer #(
  parameter int APR   = 32,
  parameter int SPS_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clken,
  input  logic [SPS_W-1:0] sps,
  input  logic [APR-1:0]   mark_inc,
  input  logic [APR-1:0]   space_inc,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [APR-1:0]   phi_inc_o,
  output logic             sym_strobe,
  output logic             busy
);

`ifdef FSK_SEQ_FRAMING_EN
  localparam int NSYM = 10;
`else
  localparam int NSYM = 8;
`endif

  localparam logic [3:0]       LAST_IDX = 4'(NSYM - 1);
  localparam logic [SPS_W-1:0] ONE      = SPS_W'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_n;
  logic [SPS_W-1:0]  cnt, cnt_n;
  logic [SPS_W-1:0]  sps_q, sps_q_n;
  logic [3:0]        idx, idx_n;
  logic [NSYM-1:0]   shreg, shreg_n;
  logic [APR-1:0]    phi_n;
  logic              strobe_n;
  logic              busy_n;

  logic [NSYM-1:0]   frame;
  logic              sym_last;
  logic              byte_last;
  logic              xfer;

`ifdef FSK_SEQ_FRAMING_EN
  assign frame = {1'b1, in_data, 1'b0};
`else
  assign frame = in_data;
`endif

  assign sym_last  = (cnt == sps_q - ONE);
  assign byte_last = (idx == LAST_IDX);

  // The final cycle of the last symbol also accepts, so bytes chain with no idle gap
  assign in_ready = !reset &&
                    ((state == IDLE) ||
                     ((state == SHIFT) && sym_last && byte_last));

  assign xfer = in_valid & in_ready & clken;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sps_q_n  = sps_q;
    idx_n    = idx;
    shreg_n  = shreg;
    phi_n    = phi_inc_o;
    busy_n   = busy;
    strobe_n = 1'b0;
    if (clken) begin
      unique case (state)
        IDLE: begin
          phi_n = mark_inc;
        end
        SHIFT: begin
          if (!sym_last) begin
            cnt_n = cnt + ONE;
          end else if (!byte_last) begin
            cnt_n    = '0;
            idx_n    = idx + 4'd1;
            shreg_n  = shreg >> 1;
            phi_n    = shreg[1] ? mark_inc : space_inc;
            strobe_n = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            busy_n  = 1'b0;
            phi_n   = mark_inc;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      if (xfer) begin
        state_n  = SHIFT;
        shreg_n  = frame;
        sps_q_n  = (sps == '0) ? ONE : sps;
        cnt_n    = '0;
        idx_n    = '0;
        phi_n    = frame[0] ? mark_inc : space_inc;
        strobe_n = 1'b1;
        busy_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sps_q      <= ONE;
      idx        <= '0;
      shreg      <= '0;
      phi_inc_o  <= '0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sps_q      <= sps_q_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      phi_inc_o  <= phi_n;
      sym_strobe <= strobe_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// Bench for fsk_symbol_sequencer: directed and random bytes against a symbol-queue model.
// Honours FSK_SEQ_FRAMING_EN the same way as the design.
module tb_fsk_symbol_sequencer;

`ifdef FSK_SEQ_FRAMING_EN
  localparam int NSYM = 10;
`else
  localparam int NSYM = 8;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clken;
  logic [15:0] sps;
  logic [31:0] mark_inc;
  logic [31:0] space_inc;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] phi_inc_o;
  logic        sym_strobe;
  logic        busy;

  fsk_symbol_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .clken      (clken),
    .sps        (sps),
    .mark_inc   (mark_inc),
    .space_inc  (space_inc),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .phi_inc_o  (phi_inc_o),
    .sym_strobe (sym_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: queue of remaining symbol bits, front is the symbol on air
  bit          m_bits[$];
  int          m_left;
  int          m_sps;
  logic [31:0] m_phi;
  bit          m_strobe;
  bit          m_busy;
  bit          m_xfer;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    if (reset) return 1'b0;
    return !m_busy || (m_bits.size() == 1 && m_left == 1);
  endfunction

  task automatic m_clear();
    m_bits.delete();
    m_left   = 0;
    m_sps    = 1;
    m_phi    = '0;
    m_strobe = 1'b0;
    m_busy   = 1'b0;
    m_xfer   = 1'b0;
  endtask

  task automatic model_step();
    bit go;
    m_xfer   = 1'b0;
    m_strobe = 1'b0;
    if (reset) begin
      m_clear();
      return;
    end
    if (!clken) return;
    go = in_valid && m_ready();
    if (m_busy) begin
      if (m_left > 1) begin
        m_left--;
      end else begin
        void'(m_bits.pop_front());
        if (m_bits.size() > 0) begin
          m_left   = m_sps;
          m_phi    = m_bits[0] ? mark_inc : space_inc;
          m_strobe = 1'b1;
        end else begin
          m_busy = 1'b0;
          m_phi  = mark_inc;
        end
      end
    end else begin
      m_phi = mark_inc;
    end
    if (go) begin
      m_xfer = 1'b1;
      m_bits.delete();
`ifdef FSK_SEQ_FRAMING_EN
      m_bits.push_back(1'b0);
`endif
      for (int i = 0; i < 8; i++) m_bits.push_back(in_data[i]);
`ifdef FSK_SEQ_FRAMING_EN
      m_bits.push_back(1'b1);
`endif
      m_sps    = (sps == 0) ? 1 : int'(sps);
      m_left   = m_sps;
      m_phi    = m_bits[0] ? mark_inc : space_inc;
      m_strobe = 1'b1;
      m_busy   = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_phi"}, 64'(phi_inc_o), 64'(m_phi));
    chk({tag, "_strobe"}, 64'(sym_strobe), 64'(m_strobe));
    chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
    chk({tag, "_ready"}, 64'(in_ready), 64'(m_ready()));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  int n_str;
  int n_busy;
  int n_xfer;
  int n_drop;
  bit seen;

  initial begin
    reset     = 1'b1;
    clken     = 1'b0;
    sps       = 16'd4;
    mark_inc  = 32'h0400_0000;
    space_inc = 32'h0200_0000;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    m_clear();
    #1;
    check_outputs("rst0");
    tick("rst1");

    // release: first clken edge loads mark
    reset = 1'b0;
    clken = 1'b1;
    tick("rel");
    chk("rel_mark", 64'(phi_inc_o), 64'h0400_0000);

    // single byte A5, sps=4
    in_data  = 8'hA5;
    in_valid = 1'b1;
    n_str    = 0;
    n_busy   = 0;
    for (int c = 0; c < NSYM * 4 + 8; c++) begin
      tick("a5");
      if (m_xfer) in_valid = 1'b0;
      n_str  += int'(sym_strobe);
      n_busy += int'(busy);
    end
    chk("a5_strobes", 64'(n_str), 64'(NSYM));
    chk("a5_busy", 64'(n_busy), 64'(NSYM * 4));
    chk("a5_idle", 64'(phi_inc_o), 64'h0400_0000);

    // back-to-back FF then 00, sps=3
    sps      = 16'd3;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    n_xfer   = 0;
    n_drop   = 0;
    seen     = 1'b0;
    for (int c = 0; c < NSYM * 6 + 10; c++) begin
      tick("b2b");
      if (m_xfer) begin
        n_xfer++;
        if (n_xfer == 1) in_data = 8'h00;
        else in_valid = 1'b0;
      end
      if (busy) seen = 1'b1;
      if (seen && !busy && n_xfer < 2) n_drop++;
    end
    chk("b2b_xfers", 64'(n_xfer), 64'd2);
    chk("b2b_nodrop", 64'(n_drop), 64'd0);

    // clken toggling, sps=2; valid raised on a clken=0 cycle
    sps      = 16'd2;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    clken    = 1'b0;
    tick("gate0");
    chk("gate_noxfer", 64'(busy), 64'd0);
    n_busy = 0;
    for (int c = 0; c < NSYM * 4 + 8; c++) begin
      clken = ~clken;
      tick("gate");
      if (m_xfer) in_valid = 1'b0;
      n_busy += int'(busy);
    end
    chk("gate_busy", 64'(n_busy), 64'(NSYM * 4));

    // sps=0 behaves as 1
    clken    = 1'b1;
    sps      = 16'd0;
    in_data  = 8'h01;
    in_valid = 1'b1;
    n_busy   = 0;
    for (int c = 0; c < NSYM + 4; c++) begin
      tick("sps0");
      if (m_xfer) in_valid = 1'b0;
      n_busy += int'(busy);
    end
    chk("sps0_busy", 64'(n_busy), 64'(NSYM));

    // random traffic, increments and clken
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid && ($urandom % 3 == 0)) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        sps      = 16'($urandom_range(0, 3));
      end
      clken     = ($urandom % 4) != 0;
      mark_inc  = $urandom;
      space_inc = $urandom;
      tick("rnd");
      if (m_xfer && ($urandom % 2 == 0)) in_valid = 1'b0;
      else if (m_xfer) begin
        in_data = 8'($urandom);
        sps     = 16'($urandom_range(0, 3));
      end
    end

    // reset mid-byte aborts asynchronously
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    sps       = 16'd4;
    clken     = 1'b1;
    mark_inc  = 32'h0400_0000;
    space_inc = 32'h0200_0000;
    for (int c = 0; c < 12; c++) begin
      tick("pre");
      if (m_xfer) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    m_clear();
    check_outputs("arst");
    tick("arst1");
    reset = 1'b0;
    tick("rel2");
    chk("rel2_mark", 64'(phi_inc_o), 64'h0400_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
